// File: rtl/sync_event_capture.sv
// Debounced level filter feeding an edge-event FIFO with a wrapping event counter.
// Define SEC_FALLING_EDGE_EN to also queue falling events (else rising only).
module sync_event_capture #(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                 dst_clk,
    input  logic                 rst,
    input  logic                 in_sync,
    output logic                 level,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 evt_edge,
    output logic [CNT_WIDTH-1:0] evt_total,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  FLT_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]           flt_q, flt_d;
    logic                 level_q, level_d;
    logic                 push_q, push_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] tot_q, tot_d;
    logic                 ovf_q, ovf_d;

`ifdef SEC_FALLING_EDGE_EN
    logic                 push_rise_q, push_rise_d;
    logic [DEPTH-1:0]     mem_q, mem_d;
`endif

    logic full;
    logic pop;
    logic accept;
    logic drop;

    // Filter: a level toggle is registered as a pending push for the next edge.
    always_comb begin
        flt_d   = flt_q;
        level_d = level_q;
        push_d  = 1'b0;
`ifdef SEC_FALLING_EDGE_EN
        push_rise_d = push_rise_q;
`endif
        if (in_sync != level_q) begin
            if (flt_q == FLT_LAST) begin
                level_d = ~level_q;
                flt_d   = 8'd0;
`ifdef SEC_FALLING_EDGE_EN
                push_d      = 1'b1;
                push_rise_d = ~level_q;
`else
                push_d      = ~level_q;
`endif
            end else begin
                flt_d = flt_q + 8'd1;
            end
        end else begin
            flt_d = 8'd0;
        end
    end

    assign full   = (cnt_q == FULL_CNT);
    assign pop    = (cnt_q != '0) & evt_ready;
    assign accept = push_q & (~full | pop);
    assign drop   = push_q & full & ~pop;

    always_comb begin
        wr_d  = wr_q + AW'(accept);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
        tot_d = tot_q + CNT_WIDTH'(accept);
        ovf_d = ovf_q;
        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
`ifdef SEC_FALLING_EDGE_EN
        mem_d = mem_q;
        if (accept) begin
            mem_d[wr_q] = push_rise_q;
        end
`endif
    end

    always_ff @(posedge dst_clk) begin
        if (rst) begin
            flt_q   <= 8'd0;
            level_q <= 1'b0;
            push_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            tot_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef SEC_FALLING_EDGE_EN
            push_rise_q <= 1'b0;
            mem_q       <= '0;
`endif
        end else begin
            flt_q   <= flt_d;
            level_q <= level_d;
            push_q  <= push_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            tot_q   <= tot_d;
            ovf_q   <= ovf_d;
`ifdef SEC_FALLING_EDGE_EN
            push_rise_q <= push_rise_d;
            mem_q       <= mem_d;
`endif
        end
    end

    assign level     = level_q;
    assign evt_valid = (cnt_q != '0);
    assign evt_total = tot_q;
    assign overflow  = ovf_q;

`ifdef SEC_FALLING_EDGE_EN
    assign evt_edge = evt_valid & mem_q[rd_q];
`else
    assign evt_edge = 1'b1;
`endif

endmodule

// File: tb/tb_sync_event_capture.sv
// Scoreboard bench for sync_event_capture (default parameters).
// Expected event types are queued at stimulus time and checked on each pop.
module tb_sync_event_capture;

`ifdef SEC_FALLING_EDGE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic       dst_clk;
    logic       rst;
    logic       in_sync;
    logic       level;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_edge;
    logic [7:0] evt_total;
    logic       overflow;
    logic       clr_overflow;

    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    logic       sb[$];
    logic [7:0] exp_total = 8'd0;

    sync_event_capture #(
        .FILTER_CYCLES(4),
        .DEPTH        (4),
        .CNT_WIDTH    (8)
    ) dut (
        .dst_clk     (dst_clk),
        .rst         (rst),
        .in_sync     (in_sync),
        .level       (level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_edge    (evt_edge),
        .evt_total   (evt_total),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial begin
        dst_clk = 1'b0;
        forever #5 dst_clk = ~dst_clk;
    end

    // Each pop (valid & ready seen before the edge) must match the queue head.
    always @(negedge dst_clk) begin
        if (!rst && evt_valid && evt_ready) begin
            logic e;
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: evt_edge=%0b, no event queued",
                         evt_edge);
            end else begin
                e = sb.pop_front();
                if (evt_edge !== e) begin
                    errors++;
                    $display("FAIL pop_order: evt_edge=%0b expected %0b",
                             evt_edge, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge dst_clk);
        #1;
    endtask

    task automatic drive(input logic v, input int hold, input bit acc);
        bit ev;
        ev = (v == 1'b1) || FALL_EN;
        in_sync = v;
        if (ev && acc) begin
            sb.push_back(v);
            exp_total = exp_total + 8'd1;
        end
        repeat (hold) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_sync = 1'b0;
        evt_ready = 1'b0;
        clr_overflow = 1'b0;
        step();
        step();
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0 || evt_total !== 8'd0 ||
            overflow !== 1'b0 || evt_edge !== !FALL_EN) begin
            errors++;
            $display("FAIL reset: lvl=%0b vld=%0b tot=%0d ovf=%0b edge=%0b required 0 0 0 0 %0b",
                     level, evt_valid, evt_total, overflow, evt_edge, !FALL_EN);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_rise_latency();
        evt_ready = 1'b1;
        in_sync = 1'b1;
        sb.push_back(1'b1);
        exp_total = exp_total + 8'd1;
        repeat (3) step();
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL lat_level3: level=%0b expected 0", level);
        end
        step();
        checks++;
        if (level !== 1'b1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_level4: level=%0b vld=%0b expected 1 0",
                     level, evt_valid);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_edge !== 1'b1 || evt_total !== 8'd1) begin
            errors++;
            $display("FAIL lat_evt5: vld=%0b edge=%0b tot=%0d expected 1 1 1",
                     evt_valid, evt_edge, evt_total);
        end
        step();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_pop6: vld=%0b expected 0", evt_valid);
        end
    endtask

    task automatic test_glitch();
        // level is 1 here; a 3-cycle low pulse must be ignored
        in_sync = 1'b0;
        repeat (3) step();
        in_sync = 1'b1;
        repeat (6) step();
        checks++;
        if (level !== 1'b1 || evt_valid !== 1'b0 || evt_total !== exp_total) begin
            errors++;
            $display("FAIL glitch_low: lvl=%0b vld=%0b tot=%0d expected 1 0 %0d",
                     level, evt_valid, evt_total, exp_total);
        end
    endtask

    task automatic test_fall();
        drive(1'b0, 6, 1'b1);
        checks++;
        if (level !== 1'b0 || evt_total !== exp_total || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL fall: lvl=%0b tot=%0d vld=%0b expected 0 %0d 0",
                     level, evt_total, evt_valid, exp_total);
        end
        // 3-cycle high pulse from level 0
        in_sync = 1'b1;
        repeat (3) step();
        in_sync = 1'b0;
        repeat (6) step();
        checks++;
        if (level !== 1'b0 || evt_valid !== 1'b0 || evt_total !== exp_total) begin
            errors++;
            $display("FAIL glitch_high: lvl=%0b vld=%0b tot=%0d expected 0 0 %0d",
                     level, evt_valid, evt_total, exp_total);
        end
    endtask

    task automatic test_overflow();
        int  n;
        bit  ev;
        logic [7:0] base;
        n = 0;
        base = exp_total;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic v;
                v = (j == 0);
                ev = v || FALL_EN;
                drive(v, 6, n < 4);
                if (ev) n++;
            end
        end
        checks++;
        if (overflow !== 1'b1 || evt_total !== base + 8'd4 ||
            evt_valid !== 1'b1 || evt_edge !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%0b tot=%0d vld=%0b edge=%0b expected 1 %0d 1 1",
                     overflow, evt_total, evt_valid, evt_edge, base + 8'd4);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_overflow: ovf=%0b expected 0", overflow);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] base;
        base = exp_total;
        in_sync = 1'b1;
        repeat (4) step();
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1 || evt_total !== base) begin
            errors++;
            $display("FAIL set_wins: ovf=%0b tot=%0d expected 1 %0d",
                     overflow, evt_total, base);
        end
        drive(1'b0, 6, 1'b0);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] base;
        base = exp_total;
        in_sync = 1'b1;
        sb.push_back(1'b1);
        exp_total = exp_total + 8'd1;
        repeat (4) step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || evt_total !== base + 8'd1 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: ovf=%0b tot=%0d vld=%0b expected 0 %0d 1",
                     overflow, evt_total, evt_valid, base + 8'd1);
        end
        repeat (2) step();
    endtask

    task automatic test_drain();
        int k;
        pops = 0;
        evt_ready = 1'b1;
        k = 0;
        while (evt_valid && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (evt_valid !== 1'b0 || pops != 4) begin
            errors++;
            $display("FAIL drain: vld=%0b pops=%0d expected 0 4", evt_valid, pops);
        end
        repeat (3) step();
        checks++;
        if (evt_valid !== 1'b0 || sb.size() != 0 || evt_total !== exp_total) begin
            errors++;
            $display("FAIL idle_ready: vld=%0b left=%0d tot=%0d expected 0 0 %0d",
                     evt_valid, sb.size(), evt_total, exp_total);
        end
    endtask

    task automatic test_reset_midflight();
        evt_ready = 1'b0;
        // level is 1 on entry
        drive(1'b0, 6, 1'b1);
        drive(1'b1, 6, 1'b1);
        if (!FALL_EN) begin
            drive(1'b0, 6, 1'b1);
            drive(1'b1, 6, 1'b1);
        end
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: vld=%0b expected 1", evt_valid);
        end
        in_sync = 1'b0;
        repeat (2) step();
        in_sync = 1'b1;
        rst = 1'b1;
        sb.delete();
        exp_total = 8'd0;
        step();
        checks++;
        if (evt_valid !== 1'b0 || level !== 1'b0 || evt_total !== 8'd0 ||
            overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: vld=%0b lvl=%0b tot=%0d ovf=%0b expected 0 0 0 0",
                     evt_valid, level, evt_total, overflow);
        end
        rst = 1'b0;
        evt_ready = 1'b1;
        sb.push_back(1'b1);
        exp_total = 8'd1;
        repeat (7) step();
        checks++;
        if (level !== 1'b1 || evt_total !== 8'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_rise: lvl=%0b tot=%0d left=%0d expected 1 1 0",
                     level, evt_total, sb.size());
        end
    endtask

    task automatic test_wrap();
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 5, 1'b1);
            drive(1'b1, 5, 1'b1);
        end
        repeat (3) step();
        checks++;
        if (evt_total !== 8'd1 || overflow !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL total_wrap: tot=%0d ovf=%0b left=%0d expected 1 0 0",
                     evt_total, overflow, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_fall();
        test_overflow();
        test_set_wins();
        test_full_push_pop();
        test_drain();
        test_reset_midflight();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
